// File: rtl/i2c_reg_access_pkg.sv
// i2c_reg_access shared types.
// Sequencer states, rw codes, default length.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_END,
    RESP
  } seq_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int MAX_LEN_DEF = 4;

endpackage

// File: rtl/i2c_reg_access_if.sv
// Byte-level handshake to the I2C master.
// master: sequencer side; slave: I2C master side.
interface i2c_reg_access_if;

  logic       m_enable;
  logic [6:0] m_slave_addr;
  logic       m_rw;
  logic [7:0] m_wr_byte;
  logic       m_busy;
  logic [7:0] m_rd_byte;
  logic       m_ack_error;

  modport master (
    output m_enable,
    output m_slave_addr,
    output m_rw,
    output m_wr_byte,
    input  m_busy,
    input  m_rd_byte,
    input  m_ack_error
  );

  modport slave (
    input  m_enable,
    input  m_slave_addr,
    input  m_rw,
    input  m_wr_byte,
    output m_busy,
    output m_rd_byte,
    output m_ack_error
  );

endinterface

// File: rtl/i2c_reg_access.sv
// Register-level command sequencer for a byte I2C master.
// Counts busy rises to feed bytes, captures on falls.
module i2c_reg_access
  import i2c_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_rw,
  input  logic [6:0]           i_cmd_slave,
  input  logic [7:0]           i_cmd_reg,
  input  logic [2:0]           i_cmd_len,
  input  logic [8*MAX_LEN-1:0] i_cmd_wdata,
  output logic                 o_rsp_valid,
  output logic [8*MAX_LEN-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic                 o_rsp_timeout,
  i2c_reg_access_if.master     m
);

  localparam int CW  = $clog2(MAX_LEN + 2) + 1;
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  seq_state_e state_q, state_d;
  logic                 busy_prev_q;
  logic [CW-1:0]        rise_q, rise_d;
  logic                 rw_q, rw_d;
  logic [6:0]           slave_q, slave_d;
  logic [2:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_d;
  logic [8*MAX_LEN-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 en_q, en_d;
  logic                 mrw_q, mrw_d;
  logic [7:0]           wr_q, wr_d;

  logic rise, fall, active, tmo_hit, bad_len;

  assign rise    = m.m_busy & ~busy_prev_q;
  assign fall    = ~m.m_busy & busy_prev_q;
  assign active  = (state_q == ISSUE) || (state_q == WAIT_END);
  assign tmo_hit = !rise && !fall && !tmo_q &&
                   (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign bad_len = (i_cmd_len == 3'd0) ||
                   (int'(i_cmd_len) > MAX_LEN);

  // Next-state: command latch, byte feed, capture, watchdog.
  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    rw_d    = rw_q;
    slave_d = slave_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    wd_d    = wd_q;
    en_d    = en_q;
    mrw_d   = mrw_q;
    wr_d    = wr_q;
    if (active) begin
      if (fall) begin
        err_d = err_q | m.m_ack_error;
        if (rw_q == I2C_RW_READ) begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (rise_q == CW'(k + 2)) begin
              rdata_d[8*k +: 8] = m.m_rd_byte;
            end
          end
        end
      end
      if (rise || fall) begin
        wd_d = '0;
      end else if (!tmo_q) begin
        wd_d = wd_q + 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          rw_d    = i_cmd_rw;
          slave_d = i_cmd_slave;
          len_d   = i_cmd_len;
          wdata_d = i_cmd_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          rise_d  = '0;
          wd_d    = '0;
          mrw_d   = I2C_RW_WRITE;
          wr_d    = i_cmd_reg;
          if (bad_len) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            en_d    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rise) begin
          rise_d = rise_q + 1'b1;
          if (rw_q == I2C_RW_WRITE &&
              rise_q < CW'(len_q)) begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (rise_q == CW'(k)) begin
                wr_d = wdata_q[8*k +: 8];
              end
            end
          end
          if (rw_q == I2C_RW_READ &&
              rise_q == '0) begin
            mrw_d = I2C_RW_READ;
          end
          if (rise_q == CW'(len_q)) begin
            en_d    = 1'b0;
            state_d = WAIT_END;
          end
        end else if (tmo_hit) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        if (fall || (tmo_q && !m.m_busy)) begin
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d = 1'b1;
          tmo_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      busy_prev_q <= 1'b0;
      rise_q      <= '0;
      rw_q        <= 1'b0;
      slave_q     <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wd_q        <= '0;
      en_q        <= 1'b0;
      mrw_q       <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      busy_prev_q <= m.m_busy;
      rise_q      <= rise_d;
      rw_q        <= rw_d;
      slave_q     <= slave_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      wd_q        <= wd_d;
      en_q        <= en_d;
      mrw_q       <= mrw_d;
      wr_q        <= wr_d;
    end
  end

  assign o_cmd_ready    = (state_q == IDLE);
  assign o_rsp_valid    = (state_q == RESP);
  assign o_rsp_rdata    = rdata_q;
  assign o_rsp_err      = err_q;
  assign o_rsp_timeout  = tmo_q;
  assign m.m_enable     = en_q;
  assign m.m_slave_addr = slave_q;
  assign m.m_rw         = mrw_q;
  assign m.m_wr_byte    = wr_q;

endmodule
